instruction_fetch: RTL and testbench

Fetch-side initiator for the synchronous instruction memory: owns the program counter, drives the 10-bit word address, and captures the 32-bit word that arrives one clock later. Presents a valid/stall-qualified instruction stream to decode. Supports one-cycle redirect for branches and jumps. A one-entry skid buffer prevents any word from being lost when decode stalls while a read is in flight.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_skid.sv | 74 +++++++
 rtl/instruction_fetch.sv | 107 ++++++++++
 tb/tb_instruction_fetch.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared constants and types for the instruction fetch unit.
//   ADDR_W    : word-address width (PC wraps modulo 2^ADDR_W)
//   DATA_W    : instruction width
//   RESET_PC  : first address fetched after reset
//   NOP_WORD  : all-zero instruction word, also the skid buffer reset value
//   fetch_state_e : fetch FSM state, encoded as {req_v, skid_v}
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned DATA_W   = 32;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;
    localparam logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000;

    // The encoding is the pair of valid bits themselves, so no separate
    // state register exists; 2'b11 (read in flight while a word is parked)
    // must never occur.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_HOLD  = 2'b01,
        ST_FETCH = 2'b10
    } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/fetch_skid.sv
// ----------------------------------------------------------------------------
// fetch_skid
// One-entry skid register that parks a word returned by memory while decode
// is stalled, so nothing already read is lost.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   capture_i     : store data_i/pc_i and mark the entry valid
//   release_i     : entry consumed by decode; mark it empty
//   flush_i       : drop the entry (redirect); wins over capture and release
//   data_i, pc_i  : word and its address to capture
//   valid_o       : entry holds a word
//   data_o, pc_o  : parked word and its address
// ----------------------------------------------------------------------------
module fetch_skid
    import fetch_pkg::*;
#(
    parameter int unsigned AW = ADDR_W,
    parameter int unsigned DW = DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          capture_i,
    input  logic          release_i,
    input  logic          flush_i,
    input  logic [DW-1:0] data_i,
    input  logic [AW-1:0] pc_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic [AW-1:0] pc_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;
    logic [AW-1:0] pc_q,    pc_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        valid_d = valid_q;
        data_d  = data_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (capture_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            pc_d    = pc_i;
        end else if (release_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: the payload is reset as well as the valid bit; it is a single
    // register (not a memory array), and a defined instr_pc out of reset is
    // part of the visible interface.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= NOP_WORD;
            pc_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            valid_q <= valid_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign pc_o    = pc_q;

endmodule : fetch_skid

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
// Owns the program counter, issues word addresses to a synchronous
// instruction memory (data returns one cycle later) and presents a
// valid/stall-qualified instruction stream to decode. Redirects take effect
// in one cycle; a one-entry skid buffer catches the in-flight word on stall.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   stall           : decode cannot accept; output is held
//   redirect_valid  : load redirect_pc now and flush in-flight/held words
//   redirect_pc     : redirect target
//   imem_addr       : word address to memory (combinational)
//   imem_data       : memory data for the address issued last cycle
//   instr_valid     : instr/instr_pc are meaningful
//   instr, instr_pc : instruction word and its word address
// ----------------------------------------------------------------------------
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned       AW   = ADDR_W,
    parameter int unsigned       DW   = DATA_W,
    parameter logic [AW-1:0]     R_PC = RESET_PC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic [AW-1:0] imem_addr,
    input  logic [DW-1:0] imem_data,
    output logic          instr_valid,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc
);

    logic [AW-1:0] pc_q,     pc_d;
    logic          req_v_q,  req_v_d;
    logic [AW-1:0] req_pc_q, req_pc_d;

    logic          issue;
    logic          skid_capture, skid_release;
    logic          skid_v;
    logic [DW-1:0] skid_instr;
    logic [AW-1:0] skid_pc;
    fetch_state_e  state;

    assign state = fetch_state_e'({req_v_q, skid_v});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= R_PC;
            req_v_q  <= 1'b0;
            req_pc_q <= '0;
        end else begin
            pc_q     <= pc_d;
            req_v_q  <= req_v_d;
            req_pc_q <= req_pc_d;
        end
    end

    always_comb begin
        imem_addr    = redirect_valid ? redirect_pc : pc_q;
        // Issue when redirected, when decode advances, or when nothing is
        // pending at all (prefetch out of IDLE even under stall).
        issue        = redirect_valid | ~stall | (state == ST_IDLE);
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        req_v_d      = 1'b0;
        skid_capture = 1'b0;
        skid_release = 1'b0;

        if (issue) begin
            pc_d     = imem_addr + AW'(1);
            req_pc_d = imem_addr;
            req_v_d  = 1'b1;
        end

        case (state)
            // Stalled with a word arriving: park it, since no issue happens.
            ST_FETCH: skid_capture = stall & ~redirect_valid;
            ST_HOLD:  skid_release = ~stall;
            default:  ;
        endcase
    end

    fetch_skid #(
        .AW (AW),
        .DW (DW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .capture_i (skid_capture),
        .release_i (skid_release),
        .flush_i   (redirect_valid),
        .data_i    (imem_data),
        .pc_i      (req_pc_q),
        .valid_o   (skid_v),
        .data_o    (skid_instr),
        .pc_o      (skid_pc)
    );

    // The redirect cycle is always dead: whatever is showing is stale.
    assign instr_valid = (skid_v | req_v_q) & ~redirect_valid;
    assign instr       = skid_v ? skid_instr : imem_data;
    assign instr_pc    = skid_v ? skid_pc    : req_pc_q;

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
// Scoreboard bench: stimulus pushes expected {pc, word} entries; a monitor
// compares every presented instruction against the queue front and pops on
// acceptance (instr_valid & ~stall). Entries marked dropped are expected to
// be shown but then discarded by a redirect or reset.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clk            = 1'b0;
    logic        rst            = 1'b1;
    logic        stall          = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [9:0]  redirect_pc    = '0;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data      = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [9:0]  instr_pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0]  pc;
        logic [31:0] data;
        bit          dropped;
    } exp_t;

    exp_t exp_q[$];

    instruction_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    // Synchronous memory: M[k] = A000_0000 | k, one cycle read latency.
    always @(posedge clk) imem_data <= 32'hA000_0000 | {22'd0, imem_addr};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [9:0] pc, input logic [31:0] data, input bit dropped);
        exp_t e;
        e.pc      = pc;
        e.data    = data;
        e.dropped = dropped;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drop_flushed();
        while (exp_q.size() > 0 && exp_q[0].dropped) void'(exp_q.pop_front());
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            drop_flushed();
        end else begin
            check("state_11_unreachable", {31'd0, dut.req_v_q & dut.skid_v}, 32'd0);
            if (redirect_valid) begin
                check("redirect_dead_cycle", {31'd0, instr_valid}, 32'd0);
                drop_flushed();
            end else if (instr_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got pc %0d required none", instr_pc);
                end else begin
                    check("instr_pc", {22'd0, instr_pc}, {22'd0, exp_q[0].pc});
                    check("instr", instr, exp_q[0].data);
                    if (!stall) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2;
        check("reset_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("reset_imem_addr", {22'd0, imem_addr}, 32'd0);
        check("reset_instr_pc", {22'd0, instr_pc}, 32'd0);

        // Straight-line fetch, then stall on 4, release, 5 and 6.
        push(10'd0, 32'hA000_0000, 1'b0);
        push(10'd1, 32'hA000_0001, 1'b0);
        push(10'd2, 32'hA000_0002, 1'b0);
        push(10'd3, 32'hA000_0003, 1'b0);
        push(10'd4, 32'hA000_0004, 1'b0);
        push(10'd5, 32'hA000_0005, 1'b0);
        push(10'd6, 32'hA000_0006, 1'b0);

        @(posedge clk);
        #1 rst = 1'b0;
        #3;
        check("first_cycle_not_valid", {31'd0, instr_valid}, 32'd0);
        check("first_issue_addr", {22'd0, imem_addr}, 32'd0);

        cyc(5);                     // instr_pc 4 showing
        stall = 1'b1;
        cyc(3);
        stall = 1'b0;
        cyc(3);                     // 7 would show: redirect instead

        push(10'd100, 32'hA000_0064, 1'b0);
        push(10'd101, 32'hA000_0065, 1'b0);
        push(10'd102, 32'hA000_0066, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 10'd100;
        cyc(1);
        redirect_valid = 1'b0;
        cyc(2);                     // 102 showing
        stall = 1'b1;
        cyc(1);                     // HOLD with 102

        push(10'd200,  32'hA000_00C8, 1'b0);
        push(10'd1022, 32'hA000_03FE, 1'b0);
        push(10'd1023, 32'hA000_03FF, 1'b0);
        push(10'd0,    32'hA000_0000, 1'b0);
        push(10'd1,    32'hA000_0001, 1'b0);
        push(10'd2,    32'hA000_0002, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 10'd200;
        cyc(1);
        redirect_valid = 1'b0;
        cyc(2);                     // 200 held for two cycles
        stall = 1'b0;
        cyc(1);
        redirect_valid = 1'b1;
        redirect_pc    = 10'd1022;
        cyc(1);
        redirect_valid = 1'b0;
        cyc(4);                     // 2 showing
        stall = 1'b1;
        cyc(1);                     // HOLD with 2

        #1 rst = 1'b1;
        #1;
        check("async_reset_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("async_reset_imem_addr", {22'd0, imem_addr}, 32'd0);
        check("async_reset_instr_pc", {22'd0, instr_pc}, 32'd0);

        push(10'd0, 32'hA000_0000, 1'b0);
        push(10'd1, 32'hA000_0001, 1'b0);
        push(10'd2, 32'hA000_0002, 1'b0);
        stall = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(4);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cyc(1);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_instruction_fetch
